fdt_scheduler: RTL and testbench
================================

Name: fdt_scheduler

Overview:
- Schedules PICC transmissions so they honour the ISO/IEC 14443-3 Frame Delay Time (FDT): (n*128 + 20) carrier cycles when the last received bit is 0, and (n*128 + 84) when it is 1.
- Timing is measured from the last rising edge of pause_n_synchronised. Beyond the minimum, a response may only start on the 128-cycle grid.
- Sits between the rx path (framing eoc/last-bit info), the response generator (tx request) and the frame encoder (tx start). It sequences when the shared tx datapath may begin a frame.

Parameters:
- TIMING_ADJUST, 0, cycles subtracted from every FDT target to compensate downstream pipeline latency; must be < 1172.
- MIN_N, 9, minimum n in the FDT formula.
- MAX_SLOTS, 16, number of grid slots offered after the minimum FDT before the response window closes.

Ports:
- clk  input  1  carrier-rate clock
- rst_n  input  1  synchronous active-low reset
- pause_n_synchronised  input  1  synchronised PCD pause signal; 0 while in a pause
- rx_eoc  input  1  one-cycle pulse: rx frame complete
- rx_error  input  1  qualifies rx_eoc; frame invalid, no response permitted
- rx_last_bit  input  1  value of the last received bit, sampled on rx_eoc
- tx_req  input  1  level; response ready, held until tx_start
- tx_done  input  1  one-cycle pulse from encoder at end of transmission
- tx_start  output  1  one-cycle pulse; encoder begins the frame
- fdt_timeout  output  1  one-cycle pulse; window closed with no tx_req
- busy  output  1  high in WAIT_FDT, GRID and TX

Behaviour:
- Reset: synchronous, active-low, sampled on posedge clk.
  - Reset values: state=IDLE, tx_start=0, fdt_timeout=0, busy=0, counters=0, pause_prev=1, last bit latch=0.
  - Reset mid-operation aborts any state, including TX.
- Rise detect: pause_prev registers pause_n_synchronised. A rise is pause_n_synchronised=1 while pause_prev=0.
- FDT counter (11 bits):
  - Cleared to 0 on the edge that samples a rise.
  - Otherwise increments every cycle, saturating at 2047.
  - Runs in every state except TX.
- Targets (counter value at which tx_start is registered high):
  - T0 = MIN_N*128 + 20 - TIMING_ADJUST - 1
  - T1 = MIN_N*128 + 84 - TIMING_ADJUST - 1
  - Consequence: the tx_start rising edge is exactly (MIN_N*128+20/84-TIMING_ADJUST) clock periods after the edge sampling the pause rise. Defaults: 1172 or 1236 cycles.
- States:
  - IDLE: rx_eoc with rx_error=0 -> latch rx_last_bit, go WAIT_FDT. rx_eoc with rx_error=1 -> stay. tx_req ignored.
  - WAIT_FDT: busy=1. A pause rise -> IDLE (new PCD frame, response discarded). When counter == target:
    - tx_req=1 -> pulse tx_start, go TX.
    - tx_req=0 -> go GRID, slot counter=0, slot count=1.
    - If counter already > target on entry (late eoc): go GRID immediately; first slot starts 128 cycles after the most recent missed grid point.
  - GRID: busy=1.
    - 7-bit slot counter counts 0..127 and wraps.
    - On wrap to 0 with tx_req=1 -> tx_start, go TX.
    - tx_req arriving mid-slot waits for the next wrap.
    - A pause rise -> IDLE.
    - After MAX_SLOTS wraps without tx_req -> pulse fdt_timeout, go IDLE.
  - TX: busy=1. Ignores pause, rx_eoc and tx_req. tx_done -> IDLE.
- tx_start and fdt_timeout are registered single-cycle pulses, never simultaneous.
- Simultaneous events:
  - Pause rise in the same cycle as target match: the pause wins (IDLE, no tx_start).
  - rx_eoc in WAIT_FDT/GRID: ignored.
  - tx_done outside TX: ignored.

Test Plan:
- Pause rise, then rx_eoc with last bit 0, tx_req held high, TIMING_ADJUST=0 -> tx_start rises exactly 1172 cycles after the pause rise, single cycle; busy high until tx_done.
- Same with last bit 1 and TIMING_ADJUST=1100 -> tx_start at 136 cycles.
- tx_req raised 1300 cycles after the rise, last bit 0 -> tx_start at 1172+128=1300 if tx_req is present at that edge, otherwise at 1428; never off-grid.
- No tx_req, MAX_SLOTS=16 -> fdt_timeout pulse at 1172+16*128=3220 cycles, state IDLE, no tx_start.
- Pause rise at 1000 cycles while in WAIT_FDT -> no tx_start, busy=0. rx_eoc with rx_error=1 -> no response.
- rst_n low for one cycle in TX or GRID -> all outputs 0 next cycle; subsequent tx_done ignored.

Source files
------------

// File: rtl/fdt_scheduler.sv
// Frame Delay Time scheduler: decides the clock edge on which the shared tx datapath
// may start a PICC response, aligned to the 128-cycle grid after the minimum FDT.
module fdt_scheduler #(
    parameter int TIMING_ADJUST = 0,
    parameter int MIN_N         = 9,
    parameter int MAX_SLOTS     = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pause_n_synchronised,
    input  logic rx_eoc,
    input  logic rx_error,
    input  logic rx_last_bit,
    input  logic tx_req,
    input  logic tx_done,
    output logic tx_start,
    output logic fdt_timeout,
    output logic busy
);

    localparam logic [10:0] TARGET_0 = 11'(MIN_N * 128 + 20 - TIMING_ADJUST - 1);
    localparam logic [10:0] TARGET_1 = 11'(MIN_N * 128 + 84 - TIMING_ADJUST - 1);

    typedef enum logic [1:0] {IDLE, WAIT_FDT, GRID, TX} state_t;

    state_t      state_reg;
    logic [10:0] fdt_cnt_reg;
    logic [6:0]  slot_cnt_reg;
    logic [7:0]  slot_num_reg;
    logic        pause_prev_reg;
    logic        last_bit_reg;
    logic        tx_start_reg;
    logic        fdt_timeout_reg;
    logic        busy_reg;

    logic        pause_rise;
    logic [10:0] target;
    logic [10:0] late_diff;

    assign pause_rise = pause_n_synchronised & ~pause_prev_reg;
    assign target     = last_bit_reg ? TARGET_1 : TARGET_0;
    // Distance past the target when the eoc arrived too late to meet it.
    assign late_diff  = fdt_cnt_reg - target;

    assign tx_start    = tx_start_reg;
    assign fdt_timeout = fdt_timeout_reg;
    assign busy        = busy_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            fdt_cnt_reg     <= '0;
            slot_cnt_reg    <= '0;
            slot_num_reg    <= '0;
            pause_prev_reg  <= 1'b1;
            last_bit_reg    <= 1'b0;
            tx_start_reg    <= 1'b0;
            fdt_timeout_reg <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            pause_prev_reg  <= pause_n_synchronised;
            tx_start_reg    <= 1'b0;
            fdt_timeout_reg <= 1'b0;

            // The counter is frozen while transmitting; the encoder owns the air then.
            if (state_reg != TX) begin
                if (pause_rise) begin
                    fdt_cnt_reg <= '0;
                end else if (fdt_cnt_reg != 11'h7FF) begin
                    fdt_cnt_reg <= fdt_cnt_reg + 11'd1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (rx_eoc && !rx_error) begin
                        last_bit_reg <= rx_last_bit;
                        state_reg    <= WAIT_FDT;
                        busy_reg     <= 1'b1;
                    end
                end
                WAIT_FDT: begin
                    if (pause_rise) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else if (fdt_cnt_reg == target) begin
                        if (tx_req) begin
                            tx_start_reg <= 1'b1;
                            state_reg    <= TX;
                        end else begin
                            slot_cnt_reg <= '0;
                            slot_num_reg <= 8'd1;
                            state_reg    <= GRID;
                        end
                    end else if (fdt_cnt_reg > target) begin
                        // Phase the slot counter so the next wrap lands on the grid.
                        slot_cnt_reg <= late_diff[6:0];
                        slot_num_reg <= 8'(late_diff[10:7]) + 8'd1;
                        state_reg    <= GRID;
                    end
                end
                GRID: begin
                    if (pause_rise) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else if (slot_cnt_reg == 7'd127) begin
                        slot_cnt_reg <= '0;
                        if (tx_req) begin
                            tx_start_reg <= 1'b1;
                            state_reg    <= TX;
                        end else if (slot_num_reg >= 8'(MAX_SLOTS)) begin
                            fdt_timeout_reg <= 1'b1;
                            state_reg       <= IDLE;
                            busy_reg        <= 1'b0;
                        end else begin
                            slot_num_reg <= slot_num_reg + 8'd1;
                        end
                    end else begin
                        slot_cnt_reg <= slot_cnt_reg + 7'd1;
                    end
                end
                TX: begin
                    if (tx_done) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdt_scheduler.sv
// Scoreboard bench for fdt_scheduler: two instances (no adjust / adjust 1100) share stimulus,
// expected pulse kind and delay from the pause rise are queued and matched against observed pulses.
module tb_fdt_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pause_n = 1'b1;
    logic rx_eoc = 1'b0;
    logic rx_error = 1'b0;
    logic rx_last_bit = 1'b0;
    logic tx_req = 1'b0;
    logic tx_done = 1'b0;
    logic a_tx_start, a_fdt_timeout, a_busy;
    logic b_tx_start, b_fdt_timeout, b_busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rise_cyc = 0;

    typedef struct {
        bit sel_b;
        bit is_timeout;
        int delta;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fdt_scheduler #(.TIMING_ADJUST(0), .MIN_N(9), .MAX_SLOTS(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .pause_n_synchronised(pause_n),
        .rx_eoc(rx_eoc), .rx_error(rx_error), .rx_last_bit(rx_last_bit),
        .tx_req(tx_req), .tx_done(tx_done),
        .tx_start(a_tx_start), .fdt_timeout(a_fdt_timeout), .busy(a_busy)
    );

    fdt_scheduler #(.TIMING_ADJUST(1100), .MIN_N(9), .MAX_SLOTS(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .pause_n_synchronised(pause_n),
        .rx_eoc(rx_eoc), .rx_error(rx_error), .rx_last_bit(rx_last_bit),
        .tx_req(tx_req), .tx_done(tx_done),
        .tx_start(b_tx_start), .fdt_timeout(b_fdt_timeout), .busy(b_busy)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; pause_n = 1'b1; rx_eoc = 1'b0; rx_error = 1'b0;
        rx_last_bit = 1'b0; tx_req = 1'b0; tx_done = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    // Pause low for one sampled edge; the following edge samples the rise.
    task automatic pause_rise();
        pause_n = 1'b0;
        step(1);
        pause_n = 1'b1;
        rise_cyc = cyc + 1;
        step(1);
    endtask

    task automatic pulse_eoc(input bit err, input bit last_bit);
        rx_eoc = 1'b1; rx_error = err; rx_last_bit = last_bit;
        step(1);
        rx_eoc = 1'b0; rx_error = 1'b0;
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        step(1);
        tx_done = 1'b0;
    endtask

    task automatic step_to(input int delta);
        while (cyc - rise_cyc < delta) @(negedge clk);
    endtask

    // Waits for the next pulse on the selected instance and matches it against the queue head.
    task automatic wait_event(input bit sel_b, input int req_at, input int budget, input string name);
        bit seen = 1'b0;
        exp_t got, e;
        got.sel_b = sel_b; got.is_timeout = 1'b0; got.delta = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            if (req_at >= 0 && cyc - rise_cyc == req_at) tx_req = 1'b1;
            @(negedge clk);
            if (sel_b ? (b_tx_start | b_fdt_timeout) : (a_tx_start | a_fdt_timeout)) begin
                seen = 1'b1;
                got.is_timeout = sel_b ? b_fdt_timeout : a_fdt_timeout;
                got.delta = cyc - rise_cyc;
                if (sel_b ? (b_tx_start & b_fdt_timeout) : (a_tx_start & a_fdt_timeout)) begin
                    checks++; failures++;
                    $display("FAIL %s_both_pulses: tx_start and fdt_timeout together at delta %0d", name, got.delta);
                end
            end
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s_sb_empty: observed event with no expectation queued", name);
        end else begin
            e = sb.pop_front();
            if (!seen || got.is_timeout !== e.is_timeout || got.delta != e.delta) begin
                failures++;
                $display("FAIL %s: got seen=%0b timeout=%0b delta=%0d, expected timeout=%0b delta=%0d",
                         name, seen, got.is_timeout, got.delta, e.is_timeout, e.delta);
            end else begin
                $display("txn %s: %s at delta %0d", name, got.is_timeout ? "fdt_timeout" : "tx_start", got.delta);
            end
        end
        if (seen) begin
            @(negedge clk);
            checks++;
            if ((sel_b ? (b_tx_start | b_fdt_timeout) : (a_tx_start | a_fdt_timeout)) !== 1'b0) begin
                failures++;
                $display("FAIL %s_pulse_width: pulse still high, expected 0", name);
            end
        end
    endtask

    task automatic watch_quiet(input int n, input string name);
        int pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (a_tx_start | a_fdt_timeout) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL %s: %0d pulses observed, expected 0", name, pulses);
        end else begin
            $display("txn %s: quiet for %0d cycles", name, n);
        end
    endtask

    task automatic check_busy(input logic exp_a, input string name);
        checks++;
        if (a_busy !== exp_a) begin
            failures++;
            $display("FAIL %s: busy=%b expected %b", name, a_busy, exp_a);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        step(2);
        checks++;
        if ({a_tx_start, a_fdt_timeout, a_busy, b_tx_start, b_fdt_timeout, b_busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: %b expected 000000",
                     {a_tx_start, a_fdt_timeout, a_busy, b_tx_start, b_fdt_timeout, b_busy});
        end
        $display("txn reset: outputs sampled");
        do_reset();
    endtask

    task automatic test_min_fdt_bit0();
        do_reset();
        pause_rise();
        step(4);
        tx_req = 1'b1;
        pulse_eoc(1'b0, 1'b0);
        check_busy(1'b1, "bit0_busy_wait");
        sb.push_back('{1'b0, 1'b0, 1172});
        wait_event(1'b0, -1, 1400, "bit0_min_fdt");
        tx_req = 1'b0;
        step(10);
        check_busy(1'b1, "bit0_busy_tx");
        pulse_tx_done();
        check_busy(1'b0, "bit0_busy_done");
    endtask

    task automatic test_adjust_bit1();
        do_reset();
        pause_rise();
        step(3);
        tx_req = 1'b1;
        pulse_eoc(1'b0, 1'b1);
        sb.push_back('{1'b1, 1'b0, 136});
        wait_event(1'b1, -1, 300, "bit1_adjust");
        tx_req = 1'b0;
        pulse_tx_done();
    endtask

    task automatic test_grid(input int req_at, input int exp_delta, input string name);
        do_reset();
        pause_rise();
        step(4);
        pulse_eoc(1'b0, 1'b0);
        sb.push_back('{1'b0, 1'b0, exp_delta});
        wait_event(1'b0, req_at, 1700, name);
        tx_req = 1'b0;
        pulse_tx_done();
    endtask

    task automatic test_timeout();
        do_reset();
        pause_rise();
        step(4);
        pulse_eoc(1'b0, 1'b0);
        sb.push_back('{1'b0, 1'b1, 3220});
        wait_event(1'b0, -1, 3500, "timeout");
        check_busy(1'b0, "timeout_busy");
    endtask

    task automatic test_late_eoc();
        do_reset();
        pause_rise();
        tx_req = 1'b1;
        step_to(1249);
        pulse_eoc(1'b0, 1'b0);
        sb.push_back('{1'b0, 1'b0, 1300});
        wait_event(1'b0, -1, 200, "late_eoc_grid");
        tx_req = 1'b0;
        pulse_tx_done();
    endtask

    task automatic test_pause_abort();
        do_reset();
        pause_rise();
        step(4);
        tx_req = 1'b1;
        pulse_eoc(1'b0, 1'b0);
        step_to(998);
        pause_rise();
        check_busy(1'b0, "pause_abort_busy");
        watch_quiet(1400, "pause_abort_quiet");
        tx_req = 1'b0;
    endtask

    task automatic test_rx_error();
        do_reset();
        pause_rise();
        step(4);
        tx_req = 1'b1;
        pulse_eoc(1'b1, 1'b0);
        check_busy(1'b0, "rx_error_busy");
        watch_quiet(1300, "rx_error_quiet");
        tx_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        pause_rise();
        step(4);
        tx_req = 1'b1;
        pulse_eoc(1'b0, 1'b0);
        sb.push_back('{1'b0, 1'b0, 1172});
        wait_event(1'b0, -1, 1400, "reset_mid_tx_start");
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check_busy(1'b0, "reset_in_tx_busy");
        pulse_tx_done();
        check_busy(1'b0, "reset_in_tx_done_ignored");
        watch_quiet(100, "reset_in_tx_quiet");
        tx_req = 1'b0;
        // Reset while waiting in the grid.
        pause_rise();
        step(4);
        pulse_eoc(1'b0, 1'b0);
        step_to(1250);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check_busy(1'b0, "reset_in_grid_busy");
        tx_req = 1'b1;
        watch_quiet(300, "reset_in_grid_quiet");
        tx_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            pause_rise();
            step(2);
            tx_req = 1'b1;
            pulse_eoc(1'b0, 1'b0);
            sb.push_back('{1'b0, 1'b0, 1172});
            wait_event(1'b0, -1, 1400, "back_to_back");
            tx_req = 1'b0;
            step(20);
            pulse_tx_done();
            check_busy(1'b0, "back_to_back_idle");
        end
    endtask

    initial begin
        test_reset();
        test_min_fdt_bit0();
        test_adjust_bit1();
        test_grid(1299, 1300, "grid_req_on_slot");
        test_grid(1300, 1428, "grid_req_missed_slot");
        test_timeout();
        test_late_eoc();
        test_pause_abort();
        test_rx_error();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d expectations unmatched, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
